// File: rtl/reg_dest_scoreboard_pkg.sv
// rtl/reg_dest_scoreboard_pkg.sv - shared register-address types and scoreboard constants
package reg_dest_scoreboard_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_AW    = 5;
  localparam int DEF_CNT_W = 2;

  // Register address, shared with the destination-select mux and the register file
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_pend_counter.sv
// rtl/reg_pend_counter.sv - saturating-safe pending-write counter for one register
module reg_pend_counter
  import reg_dest_scoreboard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             full
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;
  logic             w_dec;

  // Upstream never increments a full counter, but guard both directions so it can never wrap
  assign w_inc = inc & ~full;
  assign w_dec = dec & nonzero;

  // Count in-flight writes; flush drops everything, simultaneous inc/dec cancel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign cnt     = r_cnt;
  assign nonzero = (r_cnt != '0);
  assign full    = (r_cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/reg_dest_scoreboard.sv
// rtl/reg_dest_scoreboard.sv - in-flight register write tracker driving decode stall
module reg_dest_scoreboard
  import reg_dest_scoreboard_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_REGS = reg_dest_scoreboard_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic                iss_wen,
  input  reg_addr_t           iss_dest,
  input  reg_addr_t           iss_rs,
  input  reg_addr_t           iss_rt,
  output logic                iss_accept,
  output logic                stall,
  input  logic                wb_valid,
  input  reg_addr_t           wb_dest,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wb_err
);

  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_nonzero;
  logic [NUM_REGS-1:0] w_full;
  logic                w_dest_full;
  logic                w_iss_write;
  logic                w_wb_orphan;
  logic                r_wb_err;

  // Register 0 is hardwired and never tracked
  assign w_cnt[0]     = '0;
  assign w_nonzero[0] = 1'b0;
  assign w_full[0]    = 1'b0;

  // One pending counter per architectural register 1..NUM_REGS-1
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    logic w_inc;
    logic w_dec;
    assign w_inc = w_iss_write & (iss_dest == reg_addr_t'(g));
    assign w_dec = wb_valid & (wb_dest == reg_addr_t'(g));
    reg_pend_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (w_inc),
      .dec    (w_dec),
      .flush  (flush),
      .cnt    (w_cnt[g]),
      .nonzero(w_nonzero[g]),
      .full   (w_full[g])
    );
  end

  // Lookups read registered state only, so a write-back releases busy one cycle later
  assign rs_busy     = (w_cnt[iss_rs] != '0);
  assign rt_busy     = (w_cnt[iss_rt] != '0);
  assign busy_vec    = w_nonzero;
  assign w_dest_full = iss_wen & (iss_dest != ZERO_REG) & w_full[iss_dest];
  assign stall       = iss_valid & (rs_busy | rt_busy | w_dest_full);
  assign iss_accept  = iss_valid & ~stall;
  assign w_iss_write = iss_accept & iss_wen & (iss_dest != ZERO_REG);

  // A write-back with nothing pending is only excused by a same-cycle issue to that register
  assign w_wb_orphan = wb_valid & (wb_dest != ZERO_REG) & ~w_nonzero[wb_dest]
                     & ~(w_iss_write & (iss_dest == wb_dest));

  // Sticky error flag; flush leaves it alone so the fault stays visible
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_err <= 1'b0;
    end else if (w_wb_orphan) begin
      r_wb_err <= 1'b1;
    end
  end

  assign wb_err = r_wb_err;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// tb/tb_reg_dest_scoreboard.sv - self-checking bench for reg_dest_scoreboard
module tb_reg_dest_scoreboard;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n, flush, iss_valid, iss_wen, wb_valid;
  logic [4:0]  iss_dest, iss_rs, iss_rt, wb_dest;
  logic        iss_accept, stall, rs_busy, rt_busy, wb_err;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt [32];
  bit m_err;

  typedef struct {
    logic        fl, v, w;
    logic [4:0]  d, rs, rt;
    logic        wv;
    logic [4:0]  wd;
    logic        e_stall, e_acc, e_rsb, e_rtb;
    logic [31:0] e_bv;
    logic        e_err;
  } vec_t;

  vec_t tbl [26];

  always #5 clk = ~clk;

  reg_dest_scoreboard #(.CNT_W(CNT_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dest(iss_dest),
    .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_accept(iss_accept), .stall(stall),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .busy_vec(busy_vec), .wb_err(wb_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int fl, input int v, input int w, input int d, input int rs,
                              input int rt, input int wv, input int wd, input int es, input int ea,
                              input int erb, input int etb, input int ebv, input int eerr);
    vec_t t;
    t.fl = 1'(fl); t.v = 1'(v); t.w = 1'(w);
    t.d = 5'(d); t.rs = 5'(rs); t.rt = 5'(rt);
    t.wv = 1'(wv); t.wd = 5'(wd);
    t.e_stall = 1'(es); t.e_acc = 1'(ea); t.e_rsb = 1'(erb); t.e_rtb = 1'(etb);
    t.e_bv = 32'(ebv); t.e_err = 1'(eerr);
    return t;
  endfunction

  function automatic bit m_busy(input int r);
    return (r != 0) && (m_cnt[r] != 0);
  endfunction

  function automatic bit m_stall();
    return iss_valid && (m_busy(int'(iss_rs)) || m_busy(int'(iss_rt)) ||
           (iss_wen && iss_dest != 0 && m_cnt[iss_dest] == CNT_MAX));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] bv = '0;
    for (int r = 0; r < 32; r++) bv[r] = m_busy(r);
    return bv;
  endfunction

  // Reference: apply one clock edge's worth of scoreboard rules to the model state
  task automatic model_update();
    bit inc, dec_ok;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0;
    end else begin
      inc    = iss_valid && !m_stall() && iss_wen && iss_dest != 0;
      dec_ok = wb_valid && wb_dest != 0 && m_cnt[wb_dest] != 0;
      if (wb_valid && wb_dest != 0 && m_cnt[wb_dest] == 0 && !(inc && iss_dest == wb_dest))
        m_err = 1;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
        if (inc)    m_cnt[iss_dest] = m_cnt[iss_dest] + 1;
        if (dec_ok) m_cnt[wb_dest]  = m_cnt[wb_dest] - 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic acc_m;
    acc_m = iss_valid && !m_stall();
    check({tag, ".stall"},    32'(stall),      32'(m_stall()));
    check({tag, ".accept"},   32'(iss_accept), 32'(acc_m));
    check({tag, ".rs_busy"},  32'(rs_busy),    32'(m_busy(int'(iss_rs))));
    check({tag, ".rt_busy"},  32'(rt_busy),    32'(m_busy(int'(iss_rt))));
    check({tag, ".busy_vec"}, busy_vec,        m_busy_vec());
    check({tag, ".wb_err"},   32'(wb_err),     32'(m_err));
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0;

    tbl[0]  = mk(0,1,1,5, 0,0,0,0,  0,1,0,0, 32'h0, 0);
    tbl[1]  = mk(0,1,0,0, 5,0,0,0,  1,0,1,0, 32'h20, 0);
    tbl[2]  = mk(0,1,0,0, 0,5,0,0,  1,0,0,1, 32'h20, 0);
    tbl[3]  = mk(0,1,0,0, 5,0,1,5,  1,0,1,0, 32'h20, 0);
    tbl[4]  = mk(0,1,0,0, 5,0,0,0,  0,1,0,0, 32'h0, 0);
    tbl[5]  = mk(0,1,1,7, 0,0,0,0,  0,1,0,0, 32'h0, 0);
    tbl[6]  = mk(0,1,1,7, 0,0,0,0,  0,1,0,0, 32'h80, 0);
    tbl[7]  = mk(0,1,1,7, 0,0,0,0,  0,1,0,0, 32'h80, 0);
    tbl[8]  = mk(0,1,1,7, 0,0,0,0,  1,0,0,0, 32'h80, 0);
    tbl[9]  = mk(0,0,0,0, 0,0,1,7,  0,0,0,0, 32'h80, 0);
    tbl[10] = mk(0,0,0,0, 0,0,1,7,  0,0,0,0, 32'h80, 0);
    tbl[11] = mk(0,0,0,0, 0,0,1,7,  0,0,0,0, 32'h80, 0);
    tbl[12] = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 32'h0, 0);
    tbl[13] = mk(0,1,1,9, 0,0,0,0,  0,1,0,0, 32'h0, 0);
    tbl[14] = mk(0,1,1,9, 0,0,1,9,  0,1,0,0, 32'h200, 0);
    tbl[15] = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 32'h200, 0);
    tbl[16] = mk(0,0,0,0, 0,0,1,9,  0,0,0,0, 32'h200, 0);
    tbl[17] = mk(0,1,1,0, 0,0,0,0,  0,1,0,0, 32'h0, 0);
    tbl[18] = mk(0,0,0,0, 0,0,1,0,  0,0,0,0, 32'h0, 0);
    tbl[19] = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 32'h0, 0);
    tbl[20] = mk(0,0,0,0, 0,0,1,12, 0,0,0,0, 32'h0, 0);
    tbl[21] = mk(0,1,1,3, 0,0,0,0,  0,1,0,0, 32'h0, 1);
    tbl[22] = mk(0,1,1,4, 0,0,0,0,  0,1,0,0, 32'h8, 1);
    tbl[23] = mk(0,1,1,31,0,0,0,0,  0,1,0,0, 32'h18, 1);
    tbl[24] = mk(1,1,1,8, 0,0,0,0,  0,1,0,0, 32'h80000018, 1);
    tbl[25] = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 32'h0, 1);

    // Reset held for two edges with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      flush = 1'($urandom); iss_valid = 1'($urandom); iss_wen = 1'($urandom);
      iss_dest = 5'($urandom); iss_rs = 5'($urandom); iss_rt = 5'($urandom);
      wb_valid = 1'($urandom); wb_dest = 5'($urandom);
      cycle();
    end
    rst_n = 1'b1; flush = 1'b0; wb_valid = 1'b0;
    iss_valid = 1'b1; iss_wen = 1'($urandom);
    iss_dest = 5'($urandom); iss_rs = 5'($urandom); iss_rt = 5'($urandom);
    #1;
    check("reset.busy_vec", busy_vec, 32'h0);
    check("reset.stall", 32'(stall), 32'h0);
    check("reset.wb_err", 32'(wb_err), 32'h0);
    check("reset.accept", 32'(iss_accept), 32'h1);
    check("reset.rs_busy", 32'(rs_busy), 32'h0);

    // Directed sequences: RAW, saturation, simultaneous inc/dec, register 0, error, flush
    for (int i = 0; i < 26; i++) begin
      flush = tbl[i].fl; iss_valid = tbl[i].v; iss_wen = tbl[i].w;
      iss_dest = tbl[i].d; iss_rs = tbl[i].rs; iss_rt = tbl[i].rt;
      wb_valid = tbl[i].wv; wb_dest = tbl[i].wd;
      #1;
      check($sformatf("vec%0d.stall", i),    32'(stall),      32'(tbl[i].e_stall));
      check($sformatf("vec%0d.accept", i),   32'(iss_accept), 32'(tbl[i].e_acc));
      check($sformatf("vec%0d.rs_busy", i),  32'(rs_busy),    32'(tbl[i].e_rsb));
      check($sformatf("vec%0d.rt_busy", i),  32'(rt_busy),    32'(tbl[i].e_rtb));
      check($sformatf("vec%0d.busy_vec", i), busy_vec,        tbl[i].e_bv);
      check($sformatf("vec%0d.wb_err", i),   32'(wb_err),     32'(tbl[i].e_err));
      cycle();
    end

    // wb_err survives flush but not reset
    rst_n = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    check("err_reset.wb_err", 32'(wb_err), 32'h0);
    check("err_reset.busy_vec", busy_vec, 32'h0);

    // Randomized traffic on a small register window so hazards collide often
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      iss_valid = 1'($urandom);
      iss_wen   = ($urandom_range(0, 3) != 0);
      iss_dest  = 5'($urandom_range(0, 7));
      iss_rs    = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      iss_rt    = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      wb_valid  = 1'($urandom);
      wb_dest   = 5'($urandom_range(0, 7));
      #1;
      check_model($sformatf("rnd%0d", i));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
